iec_drive_bus: RTL and testbench

Parametrised IEC serial-bus and CPU-phase core shared by up to `NDRIVES` emulated 15xx drives. It has four jobs:
- wired-OR the host and per-drive open-collector ATN/CLK/DATA assertions, including each drive's hardware ATN-acknowledge gate;
- synchronise and deglitch the resulting lines for the drive-side VIAs;
- detect ATN assertion for the VIA CA1 inputs;
- generate per-drive 6502/VIA phase strobes from `clk32`, with per-drive 1 MHz/2 MHz mode and halt.

It sits between the top-level IEC pins and the per-drive logic blocks.

---
 rtl/iec_drive_bus.sv | 122 ++++++++++++
 tb/tb_iec_drive_bus.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/iec_drive_bus.sv
// IEC bus core for up to NDRIVES emulated drives: wired-OR of host/drive assertions,
// synchronised deglitch filters, ATN edge detect and per-drive CPU/VIA phase strobes.
module iec_drive_bus #(
  parameter int unsigned NDRIVES  = 2,
  parameter int unsigned FILT_LEN = 2,
  parameter int unsigned DIV_LOG2 = 5
) (
  input  logic               clk32,
  input  logic               reset,
  input  logic               host_atn,
  input  logic               host_clk,
  input  logic               host_data,
  input  logic [NDRIVES-1:0] drv_en,
  input  logic [NDRIVES-1:0] drv_fast,
  input  logic [NDRIVES-1:0] drv_clk_o,
  input  logic [NDRIVES-1:0] drv_data_o,
  input  logic [NDRIVES-1:0] drv_atna,
  output logic               bus_atn,
  output logic               bus_clk,
  output logic               bus_data,
  output logic               f_atn,
  output logic               f_clk,
  output logic               f_data,
  output logic               atn_edge,
  output logic [NDRIVES-1:0] ph_r,
  output logic [NDRIVES-1:0] ph_f
);

  localparam int unsigned         CntW   = $clog2(FILT_LEN + 1);
  localparam logic [DIV_LOG2-1:0] DivH   = DIV_LOG2'(2 ** (DIV_LOG2 - 1));
  localparam logic [DIV_LOG2-1:0] DivQ   = DIV_LOG2'(2 ** (DIV_LOG2 - 2));
  localparam logic [DIV_LOG2-1:0] DivHQ  = DivH + DivQ;
  localparam logic [DIV_LOG2-1:0] DivEnd = '1;
  localparam logic [CntW-1:0]     CntEnd = CntW'(FILT_LEN - 1);

  logic [NDRIVES-1:0]       en_l_q, en_l_d, fast_l_q, fast_l_d;
  logic [NDRIVES-1:0]       ph_r_q, ph_r_d, ph_f_q, ph_f_d;
  logic [NDRIVES-1:0]       dd, dc;
  logic [DIV_LOG2-1:0]      div_q, div_d;
  logic [2:0]               raw;
  logic [2:0]               s1_q, s1_d, s2_q, s2_d, f_q, f_d;
  logic [2:0][CntW-1:0]     cnt_q, cnt_d;
  logic                     atn_prev_q, atn_prev_d, atn_edge_q, atn_edge_d;

  // ATN-ack uses the raw host ATN, never the filtered one, so no loop is formed.
  always_comb begin
    dd       = en_l_q & (drv_data_o | (drv_atna ^ {NDRIVES{host_atn}}));
    dc       = en_l_q & drv_clk_o;
    bus_atn  = host_atn;
    bus_clk  = host_clk | (|dc);
    bus_data = host_data | (|dd);
    raw      = {bus_data, bus_clk, bus_atn};
  end

  // Line filters: index 0 = ATN, 1 = CLK, 2 = DATA.
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    f_d   = f_q;
    cnt_d = cnt_q;
    for (int unsigned k = 0; k < 3; k++) begin
      if (s2_q[k] == f_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CntEnd) begin
        f_d[k]   = s2_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CntW'(1);
      end
    end
    atn_prev_d = f_q[0];
    atn_edge_d = f_q[0] & ~atn_prev_q;
  end

  // Mode/enable only latch on the last divider count so phases are never truncated.
  always_comb begin
    div_d    = div_q + DIV_LOG2'(1);
    en_l_d   = (div_q == DivEnd) ? drv_en : en_l_q;
    fast_l_d = (div_q == DivEnd) ? drv_fast : fast_l_q;
    for (int unsigned i = 0; i < NDRIVES; i++) begin
      ph_r_d[i] = en_l_q[i] & ((div_q == '0) | (fast_l_q[i] & (div_q == DivH)));
      ph_f_d[i] = en_l_q[i] & (fast_l_q[i] ? ((div_q == DivQ) | (div_q == DivHQ))
                                           : (div_q == DivH));
    end
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      en_l_q     <= '1;
      fast_l_q   <= '0;
      ph_r_q     <= '0;
      ph_f_q     <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      f_q        <= '0;
      cnt_q      <= '0;
      atn_prev_q <= 1'b0;
      atn_edge_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      en_l_q     <= en_l_d;
      fast_l_q   <= fast_l_d;
      ph_r_q     <= ph_r_d;
      ph_f_q     <= ph_f_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      f_q        <= f_d;
      cnt_q      <= cnt_d;
      atn_prev_q <= atn_prev_d;
      atn_edge_q <= atn_edge_d;
    end
  end

  assign f_atn    = f_q[0];
  assign f_clk    = f_q[1];
  assign f_data   = f_q[2];
  assign atn_edge = atn_edge_q;
  assign ph_r     = ph_r_q;
  assign ph_f     = ph_f_q;

endmodule

// File: tb/tb_iec_drive_bus.sv
// Scoreboard bench for iec_drive_bus: a cycle model built from line-history and
// period-position rules predicts each cycle's outputs; a monitor compares them.
module tb_iec_drive_bus;

  localparam int unsigned NDRV = 2;
  localparam int unsigned FL   = 2;
  localparam int unsigned DL   = 5;
  localparam int          P    = 1 << DL;

  logic            clk32 = 1'b0;
  logic            reset;
  logic            host_atn, host_clk, host_data;
  logic [NDRV-1:0] drv_en, drv_fast, drv_clk_o, drv_data_o, drv_atna;
  logic            bus_atn, bus_clk, bus_data, f_atn, f_clk, f_data, atn_edge;
  logic [NDRV-1:0] ph_r, ph_f;

  iec_drive_bus #(.NDRIVES(NDRV), .FILT_LEN(FL), .DIV_LOG2(DL)) dut (
    .clk32(clk32), .reset(reset),
    .host_atn(host_atn), .host_clk(host_clk), .host_data(host_data),
    .drv_en(drv_en), .drv_fast(drv_fast), .drv_clk_o(drv_clk_o),
    .drv_data_o(drv_data_o), .drv_atna(drv_atna),
    .bus_atn(bus_atn), .bus_clk(bus_clk), .bus_data(bus_data),
    .f_atn(f_atn), .f_clk(f_clk), .f_data(f_data), .atn_edge(atn_edge),
    .ph_r(ph_r), .ph_f(ph_f)
  );

  always #5 clk32 = ~clk32;

  typedef struct packed {
    logic [2:0]      bus;
    logic [2:0]      filt;
    logic            aedge;
    logic [NDRV-1:0] pr;
    logic [NDRV-1:0] pf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: latched per-period mode, raw bus history, filtered lines.
  bit [NDRV-1:0] en_m, fast_m;
  bit [2:0]      hist[$];
  bit [2:0]      f_m;
  bit            f_prev_m;
  int            cyc;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  function automatic logic [2:0] bus_of(input bit [NDRV-1:0] en);
    logic c, d;
    c = host_clk;
    d = host_data;
    for (int i = 0; i < NDRV; i++) begin
      if (en[i]) begin
        c = c | drv_clk_o[i];
        d = d | drv_data_o[i] | (drv_atna[i] ^ host_atn);
      end
    end
    return {d, c, host_atn};
  endfunction

  task automatic model_reset();
    en_m     = '1;
    fast_m   = '0;
    f_m      = '0;
    f_prev_m = 1'b0;
    cyc      = 0;
    hist.delete();
    repeat (FL + 2) hist.push_back(3'b000);
  endtask

  // Predicts the state seen just after the coming rising edge, for current inputs.
  task automatic model_step();
    exp_t     e;
    int       pos;
    bit       run;
    bit [2:0] rawv;
    pos  = cyc % P;
    rawv = bus_of(en_m);
    for (int i = 0; i < NDRV; i++) begin
      e.pr[i] = en_m[i] && (pos == 0 || (fast_m[i] && pos == P / 2));
      e.pf[i] = en_m[i] && (fast_m[i] ? (pos == P / 4 || pos == 3 * P / 4) : pos == P / 2);
    end
    e.aedge  = f_m[0] && !f_prev_m;
    f_prev_m = f_m[0];
    hist.push_back(rawv);
    // A line flips once its twice-delayed sample has disagreed for FL consecutive edges.
    for (int k = 0; k < 3; k++) begin
      run = 1'b1;
      for (int j = 0; j < int'(FL); j++)
        if (hist[hist.size() - 3 - j][k] == f_m[k]) run = 1'b0;
      if (run) f_m[k] = ~f_m[k];
    end
    if (hist.size() > 32) void'(hist.pop_front());
    if (pos == P - 1) begin
      en_m   = drv_en;
      fast_m = drv_fast;
    end
    e.filt = f_m;
    e.bus  = bus_of(en_m);
    cyc++;
    exp_q.push_back(e);
  endtask

  task automatic step();
    model_step();
    @(negedge clk32);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk32);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bus", 8'({bus_data, bus_clk, bus_atn}), 8'(e.bus));
        check("filt", 8'({f_data, f_clk, f_atn}), 8'(e.filt));
        check("atn_edge", 8'(atn_edge), 8'(e.aedge));
        check("ph_r", 8'(ph_r), 8'(e.pr));
        check("ph_f", 8'(ph_f), 8'(e.pf));
      end
    end
  end

  initial begin : stim
    reset      = 1'b1;
    host_atn   = 1'b0;
    host_clk   = 1'b0;
    host_data  = 1'b0;
    drv_en     = '1;
    drv_fast   = 2'b10;
    drv_clk_o  = '0;
    drv_data_o = '0;
    drv_atna   = '0;
    repeat (3) @(negedge clk32);
    check("rst_regs", 8'({f_data, f_clk, f_atn, atn_edge, ph_r, ph_f}), 8'h00);
    check("rst_bus", 8'({bus_data, bus_clk, bus_atn}), 8'h00);
    reset = 1'b0;
    model_reset();

    // Host DATA held for 10 cycles, then released.
    repeat (5) step();
    host_data = 1'b1;
    repeat (10) step();
    host_data = 1'b0;
    repeat (10) step();

    // Hardware ATN acknowledge: mismatched ATNA pulls DATA until the drive acks.
    host_atn = 1'b1;
    repeat (8) step();
    drv_atna = '1;
    repeat (8) step();
    host_atn = 1'b0;
    drv_atna = '0;
    repeat (8) step();

    // Slow/fast phases, then a mid-period mode toggle on drive 0.
    repeat (2 * P) step();
    while (cyc % P != 10) step();
    drv_fast[0] = 1'b1;
    repeat (3 * P) step();

    // Halt drive 1 while it is asserting DATA.
    drv_data_o = 2'b10;
    repeat (P / 2) step();
    drv_en = 2'b01;
    repeat (2 * P) step();
    drv_en     = '1;
    drv_data_o = '0;
    repeat (P) step();

    repeat (1500) begin
      if ($urandom_range(7) == 0) host_atn = ~host_atn;
      if ($urandom_range(5) == 0) host_clk = ~host_clk;
      if ($urandom_range(5) == 0) host_data = ~host_data;
      if ($urandom_range(15) == 0) drv_clk_o = NDRV'($urandom);
      if ($urandom_range(15) == 0) drv_data_o = NDRV'($urandom);
      if ($urandom_range(15) == 0) drv_atna = NDRV'($urandom);
      if ($urandom_range(40) == 0) drv_en = NDRV'($urandom);
      if ($urandom_range(40) == 0) drv_fast = NDRV'($urandom);
      step();
    end

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_regs", 8'({f_data, f_clk, f_atn, atn_edge, ph_r, ph_f}), 8'h00);
    check("async_bus", 8'({bus_data, bus_clk, bus_atn}), 8'(bus_of('1)));
    repeat (2) @(negedge clk32);
    reset = 1'b0;
    model_reset();
    repeat (300) begin
      if ($urandom_range(6) == 0) host_atn = ~host_atn;
      if ($urandom_range(4) == 0) host_clk = ~host_clk;
      if ($urandom_range(4) == 0) host_data = ~host_data;
      if ($urandom_range(20) == 0) drv_en = NDRV'($urandom);
      if ($urandom_range(20) == 0) drv_fast = NDRV'($urandom);
      step();
    end

    @(posedge clk32);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
